// File: rtl/intr_ctrl.sv
// intr_ctrl - multi-source interrupt controller.
//
// Collects N_SRC interrupt sources and latches each one as pending. A
// software-writable mask selects which pending sources may raise a request.
// One prioritised request goes to the cpu over the irr/ack handshake, and
// the index of the requesting source is presented on irq_id. Index 0 has the
// highest priority. Once a request is raised it is not preempted.
//
// Parameters:
//   N_SRC    number of interrupt sources (1..16)
//   ID_W     width of irq_id; 2**ID_W must be >= N_SRC
//   EDGE     1 = rising-edge sensitive sources, 0 = level sensitive
//   MASK_RST reset value of the mask register
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   src         raw interrupt sources, synchronous to clk
//   mask_we     mask write strobe
//   mask_wdata  new mask value (1 = enabled)
//   mask        current mask register
//   pending     current pending register
//   irr         interrupt request to cpu
//   irq_id      index of the requested source, valid while irr=1
//   ack         cpu acknowledge, single-cycle pulse
//
// state | meaning
// IDLE  | no request outstanding; waits for a pending and enabled source
// REQ   | irr asserted for irq_id; waits for ack

module intr_ctrl #(
  parameter int               N_SRC    = 4,
  parameter int               ID_W     = 2,
  parameter bit               EDGE     = 1'b1,
  parameter logic [N_SRC-1:0] MASK_RST = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] pending,
  output logic             irr,
  output logic [ID_W-1:0]  irq_id,
  input  logic             ack
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic [N_SRC-1:0] ev;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] active;
  logic [ID_W-1:0]  sel_id;

  // src_q is captured even during reset, so a source that is already high
  // when reset is released does not look like a fresh rising edge.
  always_ff @(posedge clk) begin
    src_q <= src;
  end

  always_comb begin
    if (EDGE) begin
      ev = src & ~src_q;
    end else begin
      ev = src;
    end
  end

  // Only the source currently being requested can be cleared, and only by
  // an ack that arrives while a request is outstanding.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i] = (state_q == REQ) && ack && (irq_id_q == ID_W'(i));
    end
  end

  // Set wins over clear, so an event coinciding with its own ack re-pends.
  always_comb begin
    pending_d = ev | (pending_q & ~clr);
  end

  always_comb begin
    mask_d = mask_we ? mask_wdata : mask_q;
  end

  assign active = pending_q & mask_q;

  // Lowest set index wins; scanning downward lets it overwrite the others.
  always_comb begin
    sel_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        sel_id = ID_W'(i);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      mask_q    <= MASK_RST;
      irq_id_q  <= '0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_id_q  <= irq_id_d;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. irq_id is latched on the way into REQ and held there,
  // which is what keeps a higher-priority arrival from preempting.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    unique case (state_q)
      IDLE: begin
        if (|active) begin
          state_d  = REQ;
          irq_id_d = sel_id;
        end
      end
      REQ: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    irr     = (state_q == REQ);
    irq_id  = irq_id_q;
    mask    = mask_q;
    pending = pending_q;
  end

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] src_e, src_l;
  logic       ack_e, ack_l;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic [3:0] mask_e, mask_l, pend_e, pend_l;
  logic       irr_e, irr_l;
  logic [1:0] id_e, id_l;

  int n_vec  = 0;
  int n_miss = 0;

  intr_ctrl #(.N_SRC(4), .ID_W(2), .EDGE(1'b1), .MASK_RST(4'hF)) u_dut_edge (
    .clk        (clk),
    .reset      (reset),
    .src        (src_e),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask       (mask_e),
    .pending    (pend_e),
    .irr        (irr_e),
    .irq_id     (id_e),
    .ack        (ack_e)
  );

  intr_ctrl #(.N_SRC(4), .ID_W(2), .EDGE(1'b0), .MASK_RST(4'hF)) u_dut_level (
    .clk        (clk),
    .reset      (reset),
    .src        (src_l),
    .mask_we    (1'b0),
    .mask_wdata (4'h0),
    .mask       (mask_l),
    .pending    (pend_l),
    .irr        (irr_l),
    .irq_id     (id_l),
    .ack        (ack_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set after this are sampled at the next edge,
  // outputs read after this reflect the edge just taken.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; src_e = '0; src_l = '0; ack_e = 1'b0; ack_l = 1'b0;
    mask_we = 1'b0; mask_wdata = '0;
    step(); step();
    reset = 1'b0;
    step();
    check_val("rst_pend",   pend_e, 4'h0);
    check_val("rst_mask",   mask_e, 4'hF);
    check_val("rst_irr",    irr_e,  1'b0);
    check_val("rst_id",     id_e,   2'd0);
    check_val("rst_irr_l",  irr_l,  1'b0);

    // single edge on src[2]
    src_e = 4'b0100; step();
    check_val("se_pend", pend_e, 4'b0100);
    check_val("se_irr0", irr_e,  1'b0);
    src_e = 4'b0000; step();
    check_val("se_irr",  irr_e,  1'b1);
    check_val("se_id",   id_e,   2'd2);
    step(); step();
    ack_e = 1'b1; step(); ack_e = 1'b0;
    check_val("se_ack_irr",  irr_e,  1'b0);
    check_val("se_ack_pend", pend_e, 4'b0000);
    // ack while idle must do nothing
    ack_e = 1'b1; step(); ack_e = 1'b0; step();
    check_val("idle_ack_irr",  irr_e,  1'b0);
    check_val("idle_ack_pend", pend_e, 4'b0000);

    // priority without preemption
    src_e = 4'b1000; step();
    src_e = 4'b0000; step();
    check_val("pr_id3", id_e, 2'd3);
    step();
    src_e = 4'b0001; step();
    src_e = 4'b0000;
    check_val("pr_pend", pend_e, 4'b1001);
    step();
    check_val("pr_hold_irr", irr_e, 1'b1);
    check_val("pr_hold_id",  id_e,  2'd3);
    ack_e = 1'b1; step(); ack_e = 1'b0;
    check_val("pr_gap_irr", irr_e,  1'b0);
    check_val("pr_pend2",   pend_e, 4'b0001);
    step();
    check_val("pr_next_irr", irr_e, 1'b1);
    check_val("pr_next_id",  id_e,  2'd0);
    ack_e = 1'b1; step(); ack_e = 1'b0; step();

    // masking
    mask_we = 1'b1; mask_wdata = 4'b1110; step(); mask_we = 1'b0;
    check_val("mk_mask", mask_e, 4'b1110);
    src_e = 4'b0001; step(); src_e = 4'b0000;
    check_val("mk_pend", pend_e, 4'b0001);
    step(); step();
    check_val("mk_irr_off", irr_e, 1'b0);
    mask_we = 1'b1; mask_wdata = 4'b1111; step(); mask_we = 1'b0;
    check_val("mk_irr_wcyc", irr_e, 1'b0);
    step();
    check_val("mk_irr_on", irr_e, 1'b1);
    check_val("mk_id",     id_e,  2'd0);
    ack_e = 1'b1; step(); ack_e = 1'b0; step();

    // set/clear collision on src[1]
    src_e = 4'b0010; step();
    src_e = 4'b0000; step();
    check_val("col_id", id_e, 2'd1);
    src_e = 4'b0010; ack_e = 1'b1; step();
    src_e = 4'b0000; ack_e = 1'b0;
    check_val("col_pend", pend_e, 4'b0010);
    check_val("col_irr0", irr_e,  1'b0);
    step();
    check_val("col_irr1", irr_e, 1'b1);
    check_val("col_id2",  id_e,  2'd1);
    ack_e = 1'b1; step(); ack_e = 1'b0;
    check_val("col_clr", pend_e, 4'b0000);

    // level mode, held across an ack
    src_l = 4'b0100; step();
    check_val("lv_pend", pend_l, 4'b0100);
    step();
    check_val("lv_irr1", irr_l, 1'b1);
    check_val("lv_id",   id_l,  2'd2);
    ack_l = 1'b1; step(); ack_l = 1'b0;
    check_val("lv_irr0", irr_l,  1'b0);
    check_val("lv_rep",  pend_l, 4'b0100);
    step();
    check_val("lv_irr2", irr_l, 1'b1);
    check_val("lv_id2",  id_l,  2'd2);
    src_l = 4'b0000; step();
    ack_l = 1'b1; step(); ack_l = 1'b0;
    check_val("lv_drop_pend", pend_l, 4'b0000);
    step();
    check_val("lv_drop_irr", irr_l, 1'b0);

    // reset in the middle of a request
    mask_we = 1'b1; mask_wdata = 4'b0111; step(); mask_we = 1'b0;
    src_e = 4'b1010; step();
    src_e = 4'b0010;
    check_val("rs_pend", pend_e, 4'b1010);
    step();
    check_val("rs_irr", irr_e, 1'b1);
    check_val("rs_id",  id_e,  2'd1);
    reset = 1'b1; ack_e = 1'b1; step(); ack_e = 1'b0;
    check_val("rs_irr0", irr_e,  1'b0);
    check_val("rs_pend0", pend_e, 4'b0000);
    check_val("rs_mask", mask_e, 4'hF);
    reset = 1'b0; step(); step(); step();
    check_val("rs_post_irr",  irr_e,  1'b0);
    check_val("rs_post_pend", pend_e, 4'b0000);
    src_e = 4'b0000; step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
